// File: rtl/cmos_pattern_gen_if.sv
// cmos_pattern_gen_if: run-control inputs and OV-style sensor outputs of the pattern generator
interface cmos_pattern_gen_if;
  logic        en;
  logic [1:0]  mode;
  logic        fmt;
  logic [7:0]  cmos_data;
  logic        cmos_href;
  logic        cmos_vsyn;
  logic [15:0] frame_cnt;
  logic        frame_done;
  modport master (
    input  en, mode, fmt,
    output cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done
  );
  modport slave (
    output en, mode, fmt,
    input  cmos_data, cmos_href, cmos_vsyn, frame_cnt, frame_done
  );
endinterface

// File: rtl/cmos_pattern_gen.sv
// cmos_pattern_gen: CMOS-sensor stimulus source emitting test-pattern frames with vsyn/href/data
module cmos_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 100,
  parameter int VSYNC_LEN = 1000,
  parameter int V_FRONT   = 200,
  parameter int V_BACK    = 2000
) (
  input logic              cmos_pclk,
  input logic              rst_n,
  cmos_pattern_gen_if.master bus
);
  typedef enum logic [2:0] {IDLE, VSYNC, VFRONT, HBLANK, ACTIVE, VBACK} state_t;
  localparam logic [31:0] VS_LAST  = 32'(VSYNC_LEN - 1);
  localparam logic [31:0] VF_LAST  = 32'(V_FRONT - 1);
  localparam logic [31:0] HB_LAST  = 32'(H_BLANK - 1);
  localparam logic [31:0] VB_LAST  = 32'(V_BACK - 1);
  localparam logic [31:0] VA_LAST  = 32'(V_ACTIVE - 1);
  localparam logic [31:0] BAR_LAST = 32'(H_ACTIVE / 8 - 1);
  localparam logic [31:0] Y8_LAST  = 32'(H_ACTIVE - 1);
  localparam logic [31:0] RGB_LAST = 32'(2 * H_ACTIVE - 1);
  localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, x_q, x_d, y_q, y_d, bar_cnt_q, bar_cnt_d, line_last;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  mode_q, mode_d;
  logic        phase_q, phase_d, fmt_q, fmt_d, start, chk;
  logic [15:0] fid_q, fid_d, frame_cnt_q, frame_cnt_d, pix;
  logic [7:0]  y8, data_q, data_d;
  logic        href_q, href_d, vsyn_q, vsyn_d, frame_done_q, frame_done_d;
  // Frame sequencing: state, cycle counter, pixel/line/bar position and per-frame latches
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    bar_d       = bar_q;
    bar_cnt_d   = bar_cnt_q;
    mode_d      = mode_q;
    fmt_d       = fmt_q;
    fid_d       = fid_q;
    start       = 1'b0;
    line_last   = fmt_q ? Y8_LAST : RGB_LAST;
    case (state_q)
      IDLE: start = bus.en;
      VSYNC: begin
        cnt_d   = cnt_q == VS_LAST ? '0 : cnt_q + 32'd1;
        state_d = cnt_q == VS_LAST ? VFRONT : VSYNC;
      end
      VFRONT: begin
        cnt_d   = cnt_q == VF_LAST ? '0 : cnt_q + 32'd1;
        state_d = cnt_q == VF_LAST ? HBLANK : VFRONT;
        y_d     = '0;
      end
      HBLANK: begin
        cnt_d     = cnt_q == HB_LAST ? '0 : cnt_q + 32'd1;
        state_d   = cnt_q == HB_LAST ? ACTIVE : HBLANK;
        x_d       = '0;
        phase_d   = 1'b0;
        bar_d     = '0;
        bar_cnt_d = '0;
      end
      ACTIVE: begin
        if (cnt_q == line_last) begin
          cnt_d     = '0;
          x_d       = '0;
          phase_d   = 1'b0;
          bar_d     = '0;
          bar_cnt_d = '0;
          y_d       = y_q == VA_LAST ? '0 : y_q + 32'd1;
          state_d   = y_q == VA_LAST ? VBACK : HBLANK;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (fmt_q || phase_q) begin
            phase_d   = 1'b0;
            x_d       = x_q + 32'd1;
            bar_cnt_d = bar_cnt_q == BAR_LAST ? '0 : bar_cnt_q + 32'd1;
            bar_d     = bar_cnt_q == BAR_LAST ? bar_q + 3'd1 : bar_q;
          end else begin
            phase_d = 1'b1;
          end
        end
      end
      VBACK: begin
        cnt_d   = cnt_q == VB_LAST ? '0 : cnt_q + 32'd1;
        state_d = cnt_q == VB_LAST ? IDLE : VBACK;
        start   = cnt_q == VB_LAST && bus.en;
      end
      default: state_d = IDLE;
    endcase
    frame_done_d = state_d == VBACK && cnt_d == VB_LAST;
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_d};
    if (start) begin
      state_d = VSYNC;
      cnt_d   = '0;
      mode_d  = bus.mode;
      fmt_d   = bus.fmt;
      fid_d   = frame_cnt_q;
    end
    vsyn_d = state_d == VSYNC;
    href_d = state_d == ACTIVE;
  end
  // Pixel byte for the upcoming cycle, derived from next-state position so data aligns with href
  always_comb begin
    chk    = x_d[3] ^ y_d[3];
    pix    = mode_d == 2'd0 ? BAR_RGB[bar_d] :
             mode_d == 2'd1 ? {x_d[4:0], x_d[5:0], x_d[4:0]} :
             mode_d == 2'd2 ? {16{~chk}} : fid_d;
    y8     = mode_d == 2'd0 ? 8'hFF - {bar_d, 5'b0} :
             mode_d == 2'd1 ? x_d[7:0] :
             mode_d == 2'd2 ? {8{~chk}} : fid_d[7:0];
    data_d = !href_d ? 8'h00 : fmt_d ? y8 : phase_d ? pix[7:0] : pix[15:8];
  end
  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      bar_q        <= '0;
      bar_cnt_q    <= '0;
      mode_q       <= '0;
      fmt_q        <= 1'b0;
      fid_q        <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
      href_q       <= 1'b0;
      vsyn_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      bar_q        <= bar_d;
      bar_cnt_q    <= bar_cnt_d;
      mode_q       <= mode_d;
      fmt_q        <= fmt_d;
      fid_q        <= fid_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      data_q       <= data_d;
      href_q       <= href_d;
      vsyn_q       <= vsyn_d;
    end
  end
  assign bus.cmos_data  = data_q;
  assign bus.cmos_href  = href_q;
  assign bus.cmos_vsyn  = vsyn_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_cmos_pattern_gen.sv
// tb_cmos_pattern_gen: table-driven frame checks with a byte scoreboard for cmos_pattern_gen
module tb_cmos_pattern_gen;
  localparam int HA = 16, VA = 4, HB = 4, VS = 3, VF = 2, VB = 5;
  typedef struct {
    logic [1:0] mode;
    logic       fmt;
    logic       mid;
    int         period;
    int         bytes;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, mon_on = 1'b0, prev_vsyn = 1'b0;
  logic [7:0] q[$];
  logic [7:0] exp_b;
  int tests = 0, fails = 0, cyc = 0, fstart = 0, last_done = 0;
  int vs_n = 0, hb_n = 0, fd_n = 0, idle_act = 0, exp_cnt = 0, n;
  vec_t tbl [8];
  cmos_pattern_gen_if bus ();
  cmos_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LEN(VS),
                     .V_FRONT(VF), .V_BACK(VB)) dut (.cmos_pclk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] exp_byte(input logic [1:0] m, input logic f, input int x,
                                          input int y, input int b, input logic [15:0] fid);
    int bar;
    logic c;
    logic [15:0] p;
    logic [7:0] y8;
    bar = x / (HA / 8);
    c = ((x / 8) + (y / 8)) % 2 == 1;
    p = 16'h0000;
    y8 = 8'h00;
    case (m)
      2'd0: begin
        case (bar)
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
        y8 = 8'(255 - 32 * bar);
      end
      2'd1: begin
        p = 16'(((x % 32) << 11) | ((x % 64) << 5) | (x % 32));
        y8 = 8'(x % 256);
      end
      2'd2: begin
        p = c ? 16'h0000 : 16'hFFFF;
        y8 = c ? 8'h00 : 8'hFF;
      end
      default: begin
        p = fid;
        y8 = fid[7:0];
      end
    endcase
    return f ? y8 : (b == 0 ? p[15:8] : p[7:0]);
  endfunction
  task automatic push_frame(input logic [1:0] m, input logic f, input int fid);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        for (int b = 0; b < (f ? 1 : 2); b++)
          q.push_back(exp_byte(m, f, x, y, b, 16'(fid)));
  endtask
  task automatic wait_done(input string name, input int period, input int bytes);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!bus.frame_done && k < 1000);
    exp_cnt++;
    if (!bus.frame_done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no frame_done within %0d cycles", name, k);
    end else begin
      chk({name, "_period"}, 32'(last_done - fstart + 1), 32'(period));
      chk({name, "_vsyn_len"}, 32'(vs_n), 32'(VS));
      chk({name, "_href_bytes"}, 32'(hb_n), 32'(bytes));
      chk({name, "_done_pulses"}, 32'(fd_n), 32'd1);
      chk({name, "_bytes_left"}, 32'(q.size()), 32'd0);
      chk({name, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(exp_cnt));
    end
  endtask
  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (bus.cmos_vsyn && !prev_vsyn) begin
        fstart = cyc;
        vs_n = 0;
        hb_n = 0;
        fd_n = 0;
      end
      prev_vsyn = bus.cmos_vsyn;
      if (bus.cmos_vsyn) vs_n++;
      if (bus.cmos_href) hb_n++;
      if (bus.frame_done) begin
        fd_n++;
        last_done = cyc;
      end
      if (bus.cmos_vsyn || bus.cmos_href || bus.frame_done) idle_act++;
      if (bus.cmos_href) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %0h expected no href", bus.cmos_data);
        end else begin
          exp_b = q.pop_front();
          chk("pixel_byte", 32'(bus.cmos_data), 32'(exp_b));
        end
      end else begin
        chk("blank_data", 32'(bus.cmos_data), 32'd0);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{2'd0, 1'b0, 1'b0, 154, 128};
    tbl[1] = '{2'd2, 1'b1, 1'b0, 90, 64};
    tbl[2] = '{2'd1, 1'b0, 1'b0, 154, 128};
    tbl[3] = '{2'd1, 1'b1, 1'b0, 90, 64};
    tbl[4] = '{2'd3, 1'b1, 1'b1, 90, 64};
    tbl[5] = '{2'd3, 1'b0, 1'b0, 154, 128};
    tbl[6] = '{2'd3, 1'b1, 1'b1, 90, 64};
    tbl[7] = '{2'd0, 1'b1, 1'b0, 90, 64};
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.fmt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", 32'(bus.cmos_data), 32'd0);
    chk("rst_href", 32'(bus.cmos_href), 32'd0);
    chk("rst_vsyn", 32'(bus.cmos_vsyn), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    idle_act = 0;
    repeat (50) @(negedge clk);
    #1;
    chk("idle_activity", 32'(idle_act), 32'd0);
    chk("idle_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    bus.mode = tbl[0].mode;
    bus.fmt = tbl[0].fmt;
    push_frame(tbl[0].mode, tbl[0].fmt, exp_cnt);
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].mid) begin
        repeat (20) @(negedge clk);
        #1;
        bus.mode = ~bus.mode;
        bus.fmt = ~bus.fmt;
      end
      wait_done($sformatf("frame%0d", i), tbl[i].period, tbl[i].bytes);
      if (i < 7) begin
        bus.mode = tbl[i + 1].mode;
        bus.fmt = tbl[i + 1].fmt;
        push_frame(tbl[i + 1].mode, tbl[i + 1].fmt, exp_cnt);
      end
    end
    bus.mode = 2'd0;
    bus.fmt = 1'b1;
    push_frame(2'd0, 1'b1, exp_cnt);
    repeat (3) @(negedge clk);
    #1;
    n = 0;
    while (hb_n < 2 * HA + 2 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drop_reached_line2", 32'(n < 300), 32'd1);
    bus.en = 1'b0;
    wait_done("en_drop", 90, 64);
    idle_act = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("drop_idle_activity", 32'(idle_act), 32'd0);
    chk("drop_idle_vsyn", 32'(bus.cmos_vsyn), 32'd0);
    bus.mode = 2'd2;
    bus.fmt = 1'b0;
    push_frame(2'd2, 1'b0, exp_cnt);
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    chk("reassert_vsyn", 32'(bus.cmos_vsyn), 32'd1);
    n = 0;
    while (!bus.cmos_href && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_active", 32'(bus.cmos_href), 32'd1);
    rst_n = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_href", 32'(bus.cmos_href), 32'd0);
    chk("midrst_data", 32'(bus.cmos_data), 32'd0);
    chk("midrst_vsyn", 32'(bus.cmos_vsyn), 32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    rst_n = 1'b1;
    q.delete();
    exp_cnt = 0;
    idle_act = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_idle_activity", 32'(idle_act), 32'd0);
    bus.mode = 2'd3;
    bus.fmt = 1'b1;
    push_frame(2'd3, 1'b1, exp_cnt);
    bus.en = 1'b1;
    wait_done("post_reset", 90, 64);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
